// File: rtl/adder64_arbiter_if.sv
// Bundle of requester, adder and result signals shared by the round-robin adder arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface adder64_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ*8-1:0]  req_cin;
  logic [NUM_REQ*8-1:0]  req_cmsk_n;

  logic                  add_rst_n;
  logic                  add_en;
  logic                  add_valid;
  logic [63:0]           add_a;
  logic [63:0]           add_b;
  logic [7:0]            add_cin;
  logic [7:0]            add_cmsk_n;
  logic [63:0]           add_sum;
  logic                  add_cout;
  logic                  add_rdy;

  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic [63:0]           res_sum;
  logic                  res_cout;
  logic [3:0]            inflight;
  logic                  err;

  modport master (
    input  req_valid, req_a, req_b, req_cin, req_cmsk_n,
    input  add_sum, add_cout, add_rdy, res_ready,
    output req_ready, add_rst_n, add_en, add_valid, add_a, add_b, add_cin, add_cmsk_n,
    output res_valid, res_id, res_sum, res_cout, inflight, err
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin, req_cmsk_n,
    output add_sum, add_cout, add_rdy, res_ready,
    input  req_ready, add_rst_n, add_en, add_valid, add_a, add_b, add_cin, add_cmsk_n,
    input  res_valid, res_id, res_sum, res_cout, inflight, err
  );
endinterface

// File: rtl/adder64_arbiter.sv
// Round-robin scheduler sharing one pipelined 64-bit adder between NUM_REQ requesters,
// with a shadow ID pipeline, a held output register and whole-pipeline stall on backpressure.
module adder64_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 9,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  adder64_arbiter_if.master bus
);

  logic                  adv_s;
  logic                  issue_s;
  logic                  hs_s;
  logic                  found_hi_s;
  logic                  found_lo_s;
  logic [ID_W-1:0]       grant_hi_s;
  logic [ID_W-1:0]       grant_lo_s;
  logic [ID_W-1:0]       grant_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [63:0]           add_a_s;
  logic [63:0]           add_b_s;
  logic [7:0]            add_cin_s;
  logic [7:0]            add_cmsk_n_s;

  logic [ID_W-1:0]       rr_q, rr_d;
  logic [LATENCY-1:0]    tag_v_q, tag_v_d;
  logic [ID_W-1:0]       tag_id_q [LATENCY];
  logic [ID_W-1:0]       tag_id_d [LATENCY];
  logic                  res_valid_q, res_valid_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [63:0]           res_sum_q, res_sum_d;
  logic                  res_cout_q, res_cout_d;
  logic [3:0]            inflight_q, inflight_d;
  logic                  err_q, err_d;

  // The whole adder stalls only when a held result blocks a result arriving at the head.
  assign adv_s   = !res_valid_q || bus.res_ready || !tag_v_q[LATENCY-1];
  assign issue_s = adv_s && (|bus.req_valid);
  assign hs_s    = res_valid_q && bus.res_ready;

  // Round-robin search: first requester at or above the pointer, else lowest requester.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    grant_hi_s = '0;
    grant_lo_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && !found_hi_s && (ID_W'(i) >= rr_q)) begin
        grant_hi_s = ID_W'(i);
        found_hi_s = 1'b1;
      end else begin
        found_hi_s = found_hi_s;
      end
      if (bus.req_valid[i] && !found_lo_s) begin
        grant_lo_s = ID_W'(i);
        found_lo_s = 1'b1;
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    if (found_hi_s) begin
      grant_s = grant_hi_s;
    end else begin
      grant_s = grant_lo_s;
    end
  end

  // Accept strobes and operand mux toward the adder; buses are zero when nothing issues.
  always_comb begin
    req_ready_s  = '0;
    add_a_s      = 64'h0;
    add_b_s      = 64'h0;
    add_cin_s    = 8'h00;
    add_cmsk_n_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_s && (grant_s == ID_W'(i))) begin
        req_ready_s[i] = 1'b1;
        add_a_s        = bus.req_a[i*64 +: 64];
        add_b_s        = bus.req_b[i*64 +: 64];
        add_cin_s      = bus.req_cin[i*8 +: 8];
        add_cmsk_n_s   = bus.req_cmsk_n[i*8 +: 8];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Next-state for the pointer, tag pipeline, output register, count and error flag.
  always_comb begin
    rr_d        = rr_q;
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    inflight_d  = inflight_q;
    err_d       = err_q;

    if (issue_s) begin
      if (grant_s == ID_W'(NUM_REQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = grant_s + ID_W'(1);
      end
    end else begin
      rr_d = rr_q;
    end

    if (adv_s) begin
      tag_v_d[0]  = issue_s;
      tag_id_d[0] = grant_s;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v_d[k]  = tag_v_q[k-1];
        tag_id_d[k] = tag_id_q[k-1];
      end
    end else begin
      tag_v_d = tag_v_q;
    end

    // A head load wins over the accept, so accept-and-load back to back leaves no bubble.
    if (adv_s && tag_v_q[LATENCY-1]) begin
      res_valid_d = 1'b1;
      res_id_d    = tag_id_q[LATENCY-1];
      res_sum_d   = bus.add_sum;
      res_cout_d  = bus.add_cout;
    end else if (hs_s) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    if (adv_s && (tag_v_q[LATENCY-1] != bus.add_rdy)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case ({issue_s, hs_s})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers with synchronous reset discarding everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      tag_v_q     <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= 64'h0;
      res_cout_q  <= 1'b0;
      inflight_q  <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.add_rst_n  = ~rst;
  assign bus.add_en     = adv_s;
  assign bus.add_valid  = issue_s;
  assign bus.add_a      = add_a_s;
  assign bus.add_b      = add_b_s;
  assign bus.add_cin    = add_cin_s;
  assign bus.add_cmsk_n = add_cmsk_n_s;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_cout   = res_cout_q;
  assign bus.inflight   = inflight_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_adder64_arbiter.sv
// Directed bench for adder64_arbiter: a 9-stage behavioural adder, an in-order result
// scoreboard, and checks of latency, fairness, backpressure, mid-flight reset and tag mismatch.
module tb_adder64_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] s;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_rdy = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int cnt;
  int peak;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [64:0] mon_r;

  logic [8:0]  pv;
  logic [63:0] ps [9];
  logic [8:0]  pc;

  adder64_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  adder64_arbiter #(.NUM_REQ(4), .LATENCY(9), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte-lane adder: lane 0 always takes cin[0]; lane j chains the previous carry
  // when cmsk_n[j] is high and takes cin[j] when the mask is active.
  function automatic logic [64:0] lane_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic [7:0] cin, input logic [7:0] cmsk_n);
    logic        c;
    logic [8:0]  t;
    logic [63:0] s;
    c = 1'b0;
    s = 64'h0;
    for (int j = 0; j < 8; j++) begin
      t = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]} +
          {8'h00, ((j == 0) || !cmsk_n[j]) ? cin[j] : c};
      s[8*j +: 8] = t[7:0];
      c = t[8];
    end
    return {c, s};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[64*i +: 64]     = {8'(i + 1), 56'h00_0000_0000_00FF};
      bus.req_b[64*i +: 64]     = 64'h0000_00FF_FFFF_FF01 << (4 * i);
      bus.req_cin[8*i +: 8]     = 8'h01 << i;
      bus.req_cmsk_n[8*i +: 8]  = ~(8'h02 << i);
    end
  endtask

  // Behavioural 9-stage adder honouring enable and its own reset.
  always @(posedge clk) begin
    if (!bus.add_rst_n) begin
      pv <= 9'h000;
    end else if (bus.add_en) begin
      mon_r = lane_add(bus.add_a, bus.add_b, bus.add_cin, bus.add_cmsk_n);
      pv    <= {pv[7:0], bus.add_valid};
      pc    <= {pc[7:0], mon_r[64]};
      ps[0] <= mon_r[63:0];
      for (int k = 1; k < 9; k++) ps[k] <= ps[k-1];
    end
  end

  assign bus.add_rdy  = pv[8] | force_rdy;
  assign bus.add_sum  = ps[8];
  assign bus.add_cout = pc[8];

  // Scoreboard: retire results in issue order, enqueue each accepted request.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_res", {63'h0, bus.res_valid}, 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("sb_id", {62'h0, bus.res_id}, {62'h0, mon_e.id});
          check_val("sb_sum", bus.res_sum, mon_e.s);
          check_val("sb_cout", {63'h0, bus.res_cout}, {63'h0, mon_e.c});
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.req_ready[i]) begin
          mon_r   = lane_add(bus.req_a[64*i +: 64], bus.req_b[64*i +: 64],
                             bus.req_cin[8*i +: 8], bus.req_cmsk_n[8*i +: 8]);
          mon_e.id = 2'(i);
          mon_e.s  = mon_r[63:0];
          mon_e.c  = mon_r[64];
          exp_q.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 4'h0;
    bus.res_ready = 1'b1;
    set_ops();

    // Reset values.
    tick();
    check_val("rst_req_ready", {60'h0, bus.req_ready}, 64'h0);
    check_val("rst_add_valid", {63'h0, bus.add_valid}, 64'h0);
    check_val("rst_add_en", {63'h0, bus.add_en}, 64'h1);
    check_val("rst_add_rst_n", {63'h0, bus.add_rst_n}, 64'h0);
    check_val("rst_res_valid", {63'h0, bus.res_valid}, 64'h0);
    check_val("rst_res_id", {62'h0, bus.res_id}, 64'h0);
    check_val("rst_res_sum", bus.res_sum, 64'h0);
    check_val("rst_res_cout", {63'h0, bus.res_cout}, 64'h0);
    check_val("rst_inflight", {60'h0, bus.inflight}, 64'h0);
    check_val("rst_err", {63'h0, bus.err}, 64'h0);
    tick();
    rst = 1'b0;

    // Single op from requester 1 with hand-computed result.
    bus.req_a[127:64]    = 64'h0000_0000_FFFF_FFFF;
    bus.req_b[127:64]    = 64'h0000_0000_0000_0001;
    bus.req_cin[15:8]    = 8'h00;
    bus.req_cmsk_n[15:8] = 8'hFF;
    bus.req_valid        = 4'b0010;
    #1;
    check_val("single_ready", {60'h0, bus.req_ready}, 64'h2);
    check_val("single_add_valid", {63'h0, bus.add_valid}, 64'h1);
    check_val("single_add_a", bus.add_a, 64'h0000_0000_FFFF_FFFF);
    check_val("single_add_cmsk", {56'h0, bus.add_cmsk_n}, 64'hFF);
    tick();
    bus.req_valid = 4'h0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_val("single_latency", 64'(lat), 64'd10);
    check_val("single_sum", bus.res_sum, 64'h0000_0001_0000_0000);
    check_val("single_cout", {63'h0, bus.res_cout}, 64'h0);
    check_val("single_id", {62'h0, bus.res_id}, 64'h1);
    tick();
    set_ops();

    // Fairness: all requesters active, pointer cleared by reset first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peak = 0;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_val($sformatf("fair_grant%0d", k), {60'h0, bus.req_ready}, 64'h1 << (k % 4));
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      tick();
    end
    bus.req_valid = 4'h0;
    cnt = 0;
    while (bus.inflight != 4'd0 && cnt < 40) begin
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      tick();
      cnt++;
    end
    check_val("fair_peak", 64'(peak), 64'd10);
    check_val("fair_drained", {60'h0, bus.inflight}, 64'h0);

    // Backpressure on a back-to-back stream, then accept-and-load every cycle.
    bus.req_valid = 4'hF;
    cnt = 0;
    while (!bus.res_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check_val("bp_first_valid", {63'h0, bus.res_valid}, 64'h1);
    bus.res_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check_val($sformatf("bp_add_en%0d", s), {63'h0, bus.add_en}, 64'h0);
      check_val($sformatf("bp_ready%0d", s), {60'h0, bus.req_ready}, 64'h0);
      check_val($sformatf("bp_hold%0d", s), bus.res_sum, exp_q[0].s);
      tick();
    end
    bus.res_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #1;
      check_val($sformatf("stream_valid%0d", s), {63'h0, bus.res_valid}, 64'h1);
      tick();
    end
    bus.req_valid = 4'h0;
    cnt = 0;
    while (bus.inflight != 4'd0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check_val("bp_drained", {60'h0, bus.inflight}, 64'h0);
    check_val("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset with five operations in flight.
    bus.req_valid = 4'hF;
    for (int s = 0; s < 5; s++) tick();
    bus.req_valid = 4'h0;
    rst = 1'b1;
    #1;
    check_val("mid_add_rst_n", {63'h0, bus.add_rst_n}, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check_val("mid_inflight", {60'h0, bus.inflight}, 64'h0);
    check_val("mid_err", {63'h0, bus.err}, 64'h0);
    for (int s = 0; s < 15; s++) begin
      check_val($sformatf("mid_no_res%0d", s), {63'h0, bus.res_valid}, 64'h0);
      tick();
    end
    bus.req_valid = 4'hF;
    #1;
    check_val("mid_rr_zero", {60'h0, bus.req_ready}, 64'h1);
    tick();
    bus.req_valid = 4'h0;
    cnt = 0;
    while (bus.inflight != 4'd0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check_val("mid_drained", {60'h0, bus.inflight}, 64'h0);

    // Tag/rdy mismatch: spurious rdy while the head stage is empty.
    #1;
    check_val("mm_err_before", {63'h0, bus.err}, 64'h0);
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    #1;
    check_val("mm_err_set", {63'h0, bus.err}, 64'h1);
    for (int s = 0; s < 3; s++) tick();
    check_val("mm_err_sticky", {63'h0, bus.err}, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("mm_err_cleared", {63'h0, bus.err}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
